uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Byte buffer and dispatcher directly upstream of UART_TX.
//   Producers push bytes at clk rate. The block pops one byte at a time, holds it stable
//   on o_tx_data, and issues a one-cycle o_tx_start to the transmitter (on UART_TX's
//   start-pulse input, in place of the button edge).
//   It waits for the transmitter's busy window to finish before dispatching the next byte.
// PARAMETERS
//   DATA_WIDTH   8    bits per byte
//   DEPTH        16   FIFO entries; power of two, >=2
//   ACK_TIMEOUT  64   clk cycles to wait for i_tx_busy to rise after o_tx_start
// PORTS
//   clk          in   1                 system clock; all logic on rising edge
//   reset        in   1                 synchronous, active-low reset
//   i_wr_en      in   1                 push strobe, one byte per cycle
//   i_wr_data    in   DATA_WIDTH        byte to push
//   o_full       out  1                 FIFO holds DEPTH entries
//   o_empty      out  1                 FIFO holds 0 entries
//   o_count      out  $clog2(DEPTH)+1   current occupancy
//   o_overflow   out  1                 sticky: a push was dropped
//   i_clr_ovf    in   1                 clears o_overflow
//   i_tx_busy    in   1                 transmitter busy (frame in progress)
//   o_tx_start   out  1                 one-cycle start pulse to transmitter
//   o_tx_data    out  DATA_WIDTH        byte being sent; stable from start until done
// BEHAVIOUR
//   Reset (reset==0 at a clk edge):
//     - pointers and count cleared; o_empty=1, o_full=0, o_count=0, o_overflow=0
//     - o_tx_start=0, o_tx_data=0, FSM to IDLE
//     - reset mid-frame abandons the frame; the byte in flight is lost.
//   FIFO:
//     - circular buffer; rd/wr pointers wrap modulo DEPTH
//     - o_count = writes accepted - pops
//     - push accepted iff i_wr_en && (!o_full || pop this cycle)
//     - push and pop in the same cycle: count unchanged, both pointers advance
//     - push while full with no pop: byte dropped, o_overflow<=1 next cycle
//     - i_clr_ovf and a new overflow in the same cycle: overflow wins, flag stays 1
//     - flags and count are registered and reflect the state after the edge
//     - data written is readable no earlier than the cycle after the write
//       (no fall-through)
//   Dispatcher FSM (registered state):
//     IDLE      : if !o_empty && !i_tx_busy -> pop. o_tx_data<=head byte.
//                 Next state START.
//     START     : o_tx_start=1 for exactly this cycle. Next state WAIT_ACK,
//                 timer cleared.
//     WAIT_ACK  : if i_tx_busy -> WAIT_DONE.
//                 Else, after ACK_TIMEOUT cycles -> IDLE (byte counted as sent,
//                 no retry).
//     WAIT_DONE : on !i_tx_busy -> IDLE.
//   Latency and rate:
//     - push into empty FIFO with TX idle: o_tx_start asserts 2 cycles after the
//       push edge
//     - back-to-back: the next pop occurs the cycle after busy falls (IDLE check)
//   o_tx_data:
//     - changes only on the pop in IDLE
//     - held through START/WAIT_ACK/WAIT_DONE and afterwards until the next pop
//   o_tx_start is never asserted in any state other than START.
//   Timeout counter: $clog2(ACK_TIMEOUT+1) bits; saturates, no wrap.
// STRUCTURE
//   - Shared package uart_pkg: DATA_WIDTH default, FSM state encoding
//     (IDLE/START/WAIT_ACK/WAIT_DONE as localparam 2-bit codes).
//   - Sub-module sync_fifo (storage, pointers, count, full/empty, overflow);
//     reusable for the RX side.
//   - Dispatcher FSM and timeout counter stay in this module.
// TESTING
//   1. Reset: hold reset=0 3 cycles with i_wr_en=1
//      -> o_empty=1, o_count=0, o_tx_start=0, o_overflow=0 throughout.
//   2. Single byte: push 0xA5 with busy=0; model busy high 10 cycles after start
//      -> exactly one o_tx_start pulse 2 cycles after the push, o_tx_data=0xA5
//         held until busy falls.
//   3. Burst: push 0x00..0x0F back-to-back with TX model busy
//      -> o_full=1 after 16 pushes; 16 start pulses in order 0x00..0x0F.
//   4. Overflow: fill 16 bytes, push 0xFF while full with no pop
//      -> byte dropped, o_overflow=1, count=16; i_clr_ovf clears it.
//   5. Simultaneous: full FIFO, push in the same cycle the IDLE pop occurs
//      -> push accepted, count stays 16, o_overflow=0.
//   6. Timeout: TX model never raises busy
//      -> FSM returns to IDLE after 64 cycles and the next byte is started.
//      Mid-frame reset -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the TX dispatcher state encoding.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [1:0] IDLE_CODE      = 2'd0;
    localparam logic [1:0] START_CODE     = 2'd1;
    localparam logic [1:0] WAIT_ACK_CODE  = 2'd2;
    localparam logic [1:0] WAIT_DONE_CODE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = IDLE_CODE,
        ST_START     = START_CODE,
        ST_WAIT_ACK  = WAIT_ACK_CODE,
        ST_WAIT_DONE = WAIT_DONE_CODE
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with registered count/flags and a sticky overflow flag.
// Head data is only valid once o_empty is low, so a write is never readable in its own cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic                    i_rd_en,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    input  logic                    i_clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_accept, rd_accept;

    always_comb begin
        rd_accept = i_rd_en && !empty_q;
        // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
        wr_accept = i_wr_en && (!full_q || rd_accept);

        wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_accept ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CW'(1);
        end

        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == '0);

        // A dropped push beats a simultaneous clear.
        if (i_wr_en && !wr_accept) begin
            overflow_d = 1'b1;
        end else if (i_clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_rd_data  = mem[rd_ptr_q];
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding UART_TX: pops one byte at a time, pulses o_tx_start, then waits
// for the transmitter's busy window (or an ack timeout) before dispatching the next byte.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    input  logic                    i_clr_ovf,
    input  logic                    i_tx_busy,
    output logic                    o_tx_start,
    output logic [DATA_WIDTH-1:0]   o_tx_data
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(ACK_TIMEOUT);

    tx_state_e             state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  pop;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (pop),
        .o_rd_data  (head_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .i_clr_ovf  (i_clr_ovf)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        o_tx_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = head_data;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                o_tx_start = 1'b1;
                timer_d    = '0;
                state_d    = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // No retry on timeout: the byte is treated as sent.
                if (i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q >= TMO_LAST) begin
                    state_d = ST_IDLE;
                end else if (timer_q != TMO_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven FIFO vectors, directed dispatcher
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_clr_ovf = 1'b0;
    logic       i_tx_busy = 1'b0;
    logic       o_full, o_empty, o_overflow, o_tx_start;
    logic [4:0] o_count;
    logic [7:0] o_tx_data;

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .i_clr_ovf  (i_clr_ovf),
        .i_tx_busy  (i_tx_busy),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference model: byte queue, sticky flag, last dispatched byte, dispatcher busy-ness.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_start = 1'b0;
    bit         m_engaged = 0;
    bit         m_just_started = 0;
    bit         m_acked = 0;
    int         m_wait = 0;

    logic [7:0] obs_d[$];
    int         obs_e[$];

    int tx_mode = 0;
    int tx_ph = 0;
    int tx_cnt = 0;
    int tx_len = 0;

    typedef struct {
        logic       rst_n;
        logic       wr;
        logic [7:0] d;
        logic       clr;
        logic       busy;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       st;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, want %0h", nm, edge_n, act, exp);
        end
    endtask

    function automatic void model_edge(input logic rst_n, input logic wr, input logic [7:0] d,
                                       input logic clr, input logic busy);
        bit pop;
        bit acc;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0; m_data = 8'h00; m_start = 1'b0;
            m_engaged = 0; m_just_started = 0; m_acked = 0; m_wait = 0;
            return;
        end
        pop = !m_engaged && (mq.size() > 0) && !busy;
        // After a start: ignore busy in the start cycle, then wait for busy to rise
        // (at most TMO cycles), then for it to fall.
        if (m_engaged) begin
            if (m_just_started) begin
                m_just_started = 0;
            end else if (!m_acked) begin
                if (busy) begin
                    m_acked = 1;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) m_engaged = 0;
                end
            end else if (!busy) begin
                m_engaged = 0;
            end
        end
        acc = wr && ((mq.size() < DEPTH) || pop);
        if (pop) begin
            m_data = mq.pop_front();
            m_engaged = 1; m_just_started = 1; m_acked = 0; m_wait = 0;
        end
        if (acc) mq.push_back(d);
        if (wr && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_start = pop;
    endfunction

    task automatic apply(input logic rst_n, input logic wr, input logic [7:0] d,
                         input logic clr, input logic busy);
        reset = rst_n; i_wr_en = wr; i_wr_data = d; i_clr_ovf = clr; i_tx_busy = busy;
        model_edge(rst_n, wr, d, clr, busy);
        @(posedge clk);
        #1;
        edge_n++;
        if (o_tx_start) begin
            obs_d.push_back(o_tx_data);
            obs_e.push_back(edge_n);
        end
    endtask

    task automatic check_model();
        chk("count", int'(o_count), mq.size());
        chk("empty", int'(o_empty), int'(mq.size() == 0));
        chk("full", int'(o_full), int'(mq.size() == DEPTH));
        chk("overflow", int'(o_overflow), int'(m_ovf));
        chk("tx_start", int'(o_tx_start), int'(m_start));
        chk("tx_data", int'(o_tx_data), int'(m_data));
    endtask

    // One cycle with the transmitter model driving i_tx_busy.
    // Modes: 0 random delay/length plus idle glitches, 1 busy 10 cycles right after
    // start, 2 never busy.
    task automatic cyc(input logic rst_n, input logic wr, input logic [7:0] d, input logic clr);
        logic busy;
        busy = 1'b0;
        if (!rst_n) tx_ph = 0;
        if (tx_ph == 1) begin
            if (tx_cnt == 0) begin
                tx_ph = 2; tx_cnt = tx_len;
            end else begin
                tx_cnt--;
            end
        end
        if (tx_ph == 2) begin
            if (tx_cnt == 0) tx_ph = 0;
            else begin busy = 1'b1; tx_cnt--; end
        end else if (tx_ph == 0 && tx_mode == 0 && rst_n) begin
            busy = ($urandom_range(0, 7) == 0);
        end
        apply(rst_n, wr, d, clr, busy);
        check_model();
        if (m_start && tx_mode != 2) begin
            tx_ph = 1;
            if (tx_mode == 1) begin
                tx_cnt = 0; tx_len = 10;
            end else begin
                tx_cnt = $urandom_range(0, 3); tx_len = $urandom_range(2, 6);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int push_e;
        int pct;

        // Table: transmitter held busy so nothing is popped; reset, fill, overflow, clear.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < DEPTH; i++)
            tbl[3 + i] = '{1'b1, 1'b1, 8'(i), 1'b0, 1'b1, i + 1, 1'b0, logic'(i == DEPTH - 1), 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].rst_n, tbl[i].wr, tbl[i].d, tbl[i].clr, tbl[i].busy);
            chk($sformatf("tbl%0d_count", i), int'(o_count), tbl[i].cnt);
            chk($sformatf("tbl%0d_empty", i), int'(o_empty), int'(tbl[i].emp));
            chk($sformatf("tbl%0d_full", i), int'(o_full), int'(tbl[i].ful));
            chk($sformatf("tbl%0d_ovf", i), int'(o_overflow), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d_start", i), int'(o_tx_start), int'(tbl[i].st));
            $display("vec %0d: count=%0d full=%0b ovf=%0b", i, o_count, o_full, o_overflow);
        end

        // Full FIFO, push in the very cycle the dispatcher pops.
        tx_mode = 1; tx_ph = 0;
        obs_d.delete(); obs_e.delete();
        cyc(1'b1, 1'b1, 8'hC3, 1'b0);
        chk("simul_count", int'(o_count), 16);
        chk("simul_ovf", int'(o_overflow), 0);
        chk("simul_start", int'(o_tx_start), 1);
        chk("simul_data", int'(o_tx_data), 8'h00);
        $display("simultaneous push/pop: count=%0d ovf=%0b", o_count, o_overflow);

        // Drain the burst: starts must come out 0x00..0x0F then 0xC3.
        for (int k = 0; k < 800 && obs_d.size() < 17; k++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("burst_nstarts", obs_d.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < obs_d.size()) chk($sformatf("burst_byte%0d", i), int'(obs_d[i]), (i < 16) ? i : 8'hC3);
        end
        $display("burst: %0d start pulses observed", obs_d.size());

        // Single byte into an empty FIFO with an idle transmitter.
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        obs_d.delete(); obs_e.delete();
        cyc(1'b1, 1'b1, 8'hA5, 1'b0);
        push_e = edge_n;
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("single_nstarts", obs_d.size(), 1);
        if (obs_d.size() > 0) begin
            // Pushed in cycle 0, start is high in cycle 2: one edge after the push edge.
            chk("single_latency", obs_e[0] - push_e, 1);
            chk("single_data", int'(obs_d[0]), 8'hA5);
        end
        $display("single: push edge %0d, starts %0d", push_e, obs_d.size());

        // Ack timeout: the transmitter never raises busy.
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        tx_mode = 2;
        obs_d.delete(); obs_e.delete();
        cyc(1'b1, 1'b1, 8'h11, 1'b0);
        cyc(1'b1, 1'b1, 8'h22, 1'b0);
        for (int k = 0; k < 200 && obs_d.size() < 2; k++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("tmo_nstarts", obs_d.size(), 2);
        if (obs_d.size() == 2) begin
            // start cycle + TMO cycles waiting + one IDLE cycle
            chk("tmo_gap", obs_e[1] - obs_e[0], TMO + 2);
            chk("tmo_data2", int'(obs_d[1]), 8'h22);
        end
        $display("timeout: %0d starts observed", obs_d.size());

        // Reset in the middle of a frame.
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        tx_mode = 1;
        cyc(1'b1, 1'b1, 8'h5A, 1'b0);
        cyc(1'b1, 1'b1, 8'h6B, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("midrst_busy_window", int'(i_tx_busy), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_data", int'(o_tx_data), 0);
        chk("midrst_count", int'(o_count), 0);
        chk("midrst_start", int'(o_tx_start), 0);
        $display("mid-frame reset: data=%0h count=%0d", o_tx_data, o_count);

        // Randomized traffic with varying push density.
        tx_mode = 0;
        for (int k = 0; k < 800; k++) begin
            pct = (k < 200) ? 20 : (k < 400) ? 50 : (k < 600) ? 90 : 35;
            cyc(1'b1, logic'($urandom_range(0, 99) < pct), 8'($urandom), logic'($urandom_range(0, 19) == 0));
        end
        $display("random: %0d cycles, queue depth %0d", 800, mq.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
